md5_round4_iter: RTL
====================

MD5_ROUND4_ITER -- requirements
Module: md5_round4_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream (round-3 stage) presents a job.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a job.
REQ-005 SHALL have ports a_in, b_in, c_in, d_in, input, 32 bits each: working state entering round 4.
REQ-006 SHALL have ports h0_in, h1_in, h2_in, h3_in, input, 32 bits each: chaining values for the current 512-bit block.
REQ-007 SHALL have port msg_in, input, 512 bits: X[0] at bits 31:0 through X[15] at bits 511:480.
REQ-008 SHALL have port out_valid, output, 1 bit: final chaining values available.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-010 SHALL have ports h0_out, h1_out, h2_out, h3_out, output, 32 bits each: updated chaining values.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 On an edge with IDLE and in_valid=1, SHALL latch a/b/c/d_in, h0..h3_in and msg_in, clear step counter j, and enter RUN.
REQ-014 SHALL ignore all input ports outside the IDLE accept edge; latched copies are used exclusively.
REQ-015 In RUN, SHALL perform exactly one round-4 step per clock for j=0..15 (MD5 steps 49..64).
REQ-016 Each step SHALL compute I=C xor (B or not D); B'=B+rotl(A+I+X[k]+T[j], s); A'=D; C'=B; D'=C; all additions mod 2^32.
REQ-017 Word index SHALL be k=(7*j) mod 16.
REQ-018 Rotate amount SHALL be s=6,10,15,21 for j mod 4 = 0,1,2,3.
REQ-019 T[j] for j=0..15 SHALL be f4292244, 432aff97, ab9423a7, fc93a039, 655b59c3, 8f0ccc92, ffeff47d, 85845dd1, 6fa87e4f, fe2ce6e0, a3014314, 4e0811a1, f7537e82, bd3af235, 2ad7d2bb, eb86d391 (hex).
REQ-020 On the edge executing j=15, SHALL register h0_out=h0+A', h1_out=h1+B', h2_out=h2+C', h3_out=h3+D' (mod 2^32) and enter DONE.
REQ-021 Latency SHALL be 16 cycles: out_valid rises exactly 16 edges after the accept edge.
REQ-022 In DONE, h*_out SHALL hold stable until the edge with out_ready=1, then FSM returns to IDLE and out_valid falls.
REQ-023 in_ready SHALL NOT be asserted in DONE, even when out_ready=1 (no same-cycle pass-through); minimum spacing between accept edges is 18 cycles.
REQ-024 out_ready held low SHALL stall indefinitely in DONE without result corruption.
REQ-025 h*_out SHALL retain the last result after leaving DONE until overwritten by the next job's completion.

Reset
REQ-026 When rst=1 at an edge, SHALL enter IDLE, clear j, and set out_valid=0 and h0..h3_out=0; in_ready=1 on the following cycle.
REQ-027 Reset in RUN or DONE SHALL abort the job; no out_valid is produced for it.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-029 Golden vector: "abc" block, round-4 inputs from a reference MD5 model, h*=67452301/efcdab89/98badcfe/10325476 -> h0..h3_out=98500190, b04fd23c, 7d3f96d6, 727fe128.
REQ-030 Latency: in_valid pulsed at edge 0 with out_ready=1 -> out_valid high for exactly 1 cycle after edge 16; in_ready low from edge 1 through edge 17.
REQ-031 Backpressure: out_ready=0 for 50 cycles after completion -> out_valid held 50+ cycles, h*_out unchanged; result consumed on first out_ready=1 edge.
REQ-032 Input isolation: change a_in..msg_in every cycle during RUN -> result equals that of the inputs latched at accept.
REQ-033 Mid-run reset: rst=1 at step j=7 -> next cycle in_ready=1, out_valid=0, h*_out=0; new job then completes normally.
REQ-034 Random regression: 1000 random jobs with random out_ready stalls vs reference model -> all outputs match, no lost or duplicated results.

Source files
------------

// File: rtl/md5_round4_iter.sv
// rtl/md5_round4_iter.sv - iterative MD5 round-4 stage with chaining-value update
//
// Takes the working state (a,b,c,d) left by round 3, runs the sixteen round-4
// steps one per clock, then adds the result to the block's chaining values.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   job handshake from the round-3 stage
//   a_in..d_in            working state entering round 4
//   h0_in..h3_in          chaining values of the current 512-bit block
//   msg_in                message block, X[0] at bits 31:0 .. X[15] at 511:480
//   out_valid / out_ready result handshake to downstream
//   h0_out..h3_out        updated chaining values
module md5_round4_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    input  logic [31:0]  h0_in,
    input  logic [31:0]  h1_in,
    input  logic [31:0]  h2_in,
    input  logic [31:0]  h3_in,
    input  logic [511:0] msg_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  h0_out,
    output logic [31:0]  h1_out,
    output logic [31:0]  h2_out,
    output logic [31:0]  h3_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   j_q, j_d;
    logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [31:0]  ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d;
    logic [511:0] msg_q, msg_d;
    logic [31:0]  ho0_q, ho0_d, ho1_q, ho1_d, ho2_q, ho2_d, ho3_q, ho3_d;

    // One round-4 step on the latched state.
    logic [6:0]  k_full;
    logic [3:0]  k_idx;
    logic [31:0] x_word;
    logic [31:0] t_const;
    logic [4:0]  s_amt;
    logic [31:0] i_fun;
    logic [31:0] step_sum;
    logic [63:0] rot_dbl;
    logic [31:0] b_new;

    always_comb begin
        // k = 7*j mod 16: the low nibble of the product.
        k_full   = {3'b000, j_q} * 7'd7;
        k_idx    = k_full[3:0];
        x_word   = msg_q[{k_idx, 5'b00000} +: 32];

        case (j_q)
            4'd0:    t_const = 32'hf4292244;
            4'd1:    t_const = 32'h432aff97;
            4'd2:    t_const = 32'hab9423a7;
            4'd3:    t_const = 32'hfc93a039;
            4'd4:    t_const = 32'h655b59c3;
            4'd5:    t_const = 32'h8f0ccc92;
            4'd6:    t_const = 32'hffeff47d;
            4'd7:    t_const = 32'h85845dd1;
            4'd8:    t_const = 32'h6fa87e4f;
            4'd9:    t_const = 32'hfe2ce6e0;
            4'd10:   t_const = 32'ha3014314;
            4'd11:   t_const = 32'h4e0811a1;
            4'd12:   t_const = 32'hf7537e82;
            4'd13:   t_const = 32'hbd3af235;
            4'd14:   t_const = 32'h2ad7d2bb;
            default: t_const = 32'heb86d391;
        endcase

        case (j_q[1:0])
            2'd0:    s_amt = 5'd6;
            2'd1:    s_amt = 5'd10;
            2'd2:    s_amt = 5'd15;
            default: s_amt = 5'd21;
        endcase

        i_fun    = c_q ^ (b_q | ~d_q);
        step_sum = a_q + i_fun + x_word + t_const;
        // Rotate-left: the upper half of the doubled word shifted left.
        rot_dbl  = {step_sum, step_sum} << s_amt;
        b_new    = b_q + rot_dbl[63:32];
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        ch2_d   = ch2_q;
        ch3_d   = ch3_q;
        msg_d   = msg_q;
        ho0_d   = ho0_q;
        ho1_d   = ho1_q;
        ho2_d   = ho2_q;
        ho3_d   = ho3_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = c_in;
                    d_d     = d_in;
                    ch0_d   = h0_in;
                    ch1_d   = h1_in;
                    ch2_d   = h2_in;
                    ch3_d   = h3_in;
                    msg_d   = msg_in;
                    j_d     = 4'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d = d_q;
                b_d = b_new;
                c_d = b_q;
                d_d = c_q;
                j_d = j_q + 4'd1;
                if (j_q == 4'd15) begin
                    // Feed-forward uses the post-step state (A'=D, B'=b_new, C'=B, D'=C).
                    ho0_d   = ch0_q + d_q;
                    ho1_d   = ch1_q + b_new;
                    ho2_d   = ch2_q + b_q;
                    ho3_d   = ch3_q + c_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and visible outputs are reset; the working datapath is not,
    // since it is always reloaded on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            j_q     <= 4'd0;
            ho0_q   <= 32'd0;
            ho1_q   <= 32'd0;
            ho2_q   <= 32'd0;
            ho3_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            ho0_q   <= ho0_d;
            ho1_q   <= ho1_d;
            ho2_q   <= ho2_d;
            ho3_q   <= ho3_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        c_q   <= c_d;
        d_q   <= d_d;
        ch0_q <= ch0_d;
        ch1_q <= ch1_d;
        ch2_q <= ch2_d;
        ch3_q <= ch3_d;
        msg_q <= msg_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign h0_out    = ho0_q;
    assign h1_out    = ho1_q;
    assign h2_out    = ho2_q;
    assign h3_out    = ho3_q;

endmodule
